ahb_sram_slave: RTL and testbench

AHB-Lite subordinate holding a small register-based word memory. It answers the transfers issued by the bus master inside `ahb_top`, one instance per `slave_sel` decode. It accepts pipelined address/data phases, inserts a configurable number of wait states, and returns a two-cycle ERROR response for unsupported transfers. It is the responder counterpart to the existing master-side path.

---
 rtl/ahb_sram_slave_if.sv | 26 ++
 rtl/ahb_sram_slave.sv | 121 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one master-side port and one SRAM subordinate.
// Request signals (hsel, haddr, htrans, hwrite, hsize, hwdata, hready) flow master -> slave;
// response signals (hrdata, hreadyout, hresp) flow slave -> master.
// hready is the interconnect-level ready and is presented to the slave as an input.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate with a register-based word memory.
// Accepts pipelined address/data phases, inserts WAIT_STATES wait cycles per OKAY transfer,
// and answers unsupported transfers (non-word size, misaligned, out of range) with a
// two-cycle ERROR response that never touches memory or hrdata.
// Ports:
//   hclk    - bus clock, rising edge
//   hresetn - asynchronous active-low reset
//   bus     - ahb_sram_slave_if.slave: request inputs, hrdata/hreadyout/hresp outputs
module ahb_sram_slave #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic             hclk,
    input logic             hresetn,
    ahb_sram_slave_if.slave bus
);
    localparam int unsigned IW         = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StLast = 3'd2;
    localparam logic [2:0] StErr1 = 3'd3;
    localparam logic [2:0] StErr2 = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [31:0]   rdata_q;
    logic [31:0]   mem_q [DEPTH];

    logic          accept;
    logic          illegal;
    logic          commit;
    logic          load;
    logic [IW-1:0] load_idx;
    logic [IW-1:0] addr_idx;
    logic [31:0]   load_data;
    logic          unused_htrans0;

    assign unused_htrans0 = bus.htrans[0];

    assign addr_idx = bus.haddr[IW+1:2];
    assign accept   = bus.hsel & bus.hready & bus.htrans[1];
    assign illegal  = (bus.hsize != 3'b010) | (bus.haddr[1:0] != 2'b00) |
                      (bus.haddr >= ADDR_LIMIT);

    // The data phase of a write ends on the edge that leaves LAST.
    assign commit = (state_q == StLast) & write_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        load     = 1'b0;
        load_idx = idx_q;
        case (state_q)
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StLast;
                    load    = ~write_q;
                end
            end
            StErr1: state_d = StErr2;
            // IDLE, LAST and ERR2 all evaluate a new address phase (back-to-back pipelining).
            default: begin
                state_d = StIdle;
                if (accept) begin
                    if (illegal) begin
                        state_d = StErr1;
                    end else begin
                        idx_d   = addr_idx;
                        write_d = bus.hwrite;
                        if (WAIT_STATES == 0) begin
                            state_d  = StLast;
                            load     = ~bus.hwrite;
                            load_idx = addr_idx;
                        end else begin
                            state_d = StWait;
                            cnt_d   = 3'(WAIT_STATES);
                        end
                    end
                end
            end
        endcase
    end

    // A write committing on the same edge to the same word forwards its data to the read.
    assign load_data = (commit && (idx_q == load_idx)) ? bus.hwdata : mem_q[load_idx];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i[IW-1:0]] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            if (load) begin
                rdata_q <= load_data;
            end
            if (commit) begin
                mem_q[idx_q] <= bus.hwdata;
            end
        end
    end

    assign bus.hrdata    = rdata_q;
    assign bus.hreadyout = ~((state_q == StWait) | (state_q == StErr1));
    assign bus.hresp     = (state_q == StErr1) | (state_q == StErr2);
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (WAIT_STATES 0, 1, 3) share one driver; only the
// selected instance sees hsel. The driver pushes the expected response of each accepted
// transfer into a queue; a monitor follows the data phases and pops/compares on completion.
module tb_ahb_sram_slave;
    localparam logic [1:0] TrIdle   = 2'b00;
    localparam logic [1:0] TrBusy   = 2'b01;
    localparam logic [1:0] TrNonseq = 2'b10;
    localparam logic [2:0] SzWord   = 3'b010;

    typedef struct {
        logic        err;
        int          nwait;
        logic [31:0] rdata;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [1:0]  dsel;
    logic        tb_hsel;
    logic [31:0] tb_haddr;
    logic [1:0]  tb_htrans;
    logic        tb_hwrite;
    logic [2:0]  tb_hsize;
    logic [31:0] tb_hwdata;

    logic [2:0]  rdy;
    logic [2:0]  rsp;
    logic [31:0] rdat [3];
    logic        m_ready;
    logic        m_resp;
    logic [31:0] m_rdata;

    exp_t        exp_q[$];
    logic [31:0] mem_m [3][16];
    logic [31:0] last_rd [3];
    int          total = 0;
    int          bad = 0;
    logic        in_data = 1'b0;

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_sram_slave_if bus ();
        assign bus.hsel   = tb_hsel & (dsel == 2'(g));
        assign bus.haddr  = tb_haddr;
        assign bus.htrans = tb_htrans;
        assign bus.hwrite = tb_hwrite;
        assign bus.hsize  = tb_hsize;
        assign bus.hwdata = tb_hwdata;
        assign bus.hready = bus.hreadyout;
        assign rdy[g]     = bus.hreadyout;
        assign rsp[g]     = bus.hresp;
        assign rdat[g]    = bus.hrdata;

        ahb_sram_slave #(
            .DEPTH      (16),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : 3)
        ) u_dut (
            .hclk   (hclk),
            .hresetn(hresetn),
            .bus    (bus)
        );
    end

    assign m_ready = rdy[dsel];
    assign m_resp  = rsp[dsel];
    assign m_rdata = rdat[dsel];

    function automatic int ws_of(input logic [1:0] d);
        return (d == 2'd0) ? 0 : (d == 2'd1) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (dut %0d, t=%0t): got %h want %h", name, dsel, $time, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            last_rd[d] = '0;
            for (int i = 0; i < 16; i++) mem_m[d][i] = '0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the address phase was sampled.
    task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata);
        exp_t e;
        int   n;
        int   idx;
        tb_hsel   = sel;
        tb_htrans = trans;
        tb_hwrite = wr;
        tb_haddr  = addr;
        tb_hsize  = size;
        if (sel && trans[1]) begin
            e.err = (size != SzWord) || (addr[1:0] != 2'b00) || (addr >= 32'd64);
            idx   = int'(addr[5:2]);
            if (!e.err && wr) mem_m[dsel][idx] = wdata;
            if (!e.err && !wr) last_rd[dsel] = mem_m[dsel][idx];
            e.nwait = e.err ? 1 : ws_of(dsel);
            e.rdata = last_rd[dsel];
            exp_q.push_back(e);
        end
        n = 0;
        @(negedge hclk);
        while (!m_ready && n < 64) begin
            n++;
            @(negedge hclk);
        end
        if (n >= 64) begin
            total++;
            bad++;
            $display("FAIL addr_phase_timeout: hreadyout=%b want 1", m_ready);
        end
        @(posedge hclk);
        #1;
        if (wr) tb_hwdata = wdata;
    endtask

    task automatic finish_seq();
        int n;
        tb_hsel   = 1'b0;
        tb_htrans = TrIdle;
        tb_hwrite = 1'b0;
        tb_hsize  = SzWord;
        n = 0;
        while ((exp_q.size() != 0 || in_data) && n < 100) begin
            @(posedge hclk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge hclk);
        #1;
    endtask

    // Monitor: samples at negedge, tracks data phases from accepted address phases.
    initial begin
        exp_t e;
        int   waits;
        logic resp_bad;
        waits    = 0;
        resp_bad = 1'b0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                in_data  = 1'b0;
                waits    = 0;
                resp_bad = 1'b0;
                exp_q.delete();
            end else begin
                if (in_data) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_data_phase: queue=0 want >0");
                        in_data = 1'b0;
                    end else begin
                        if (m_resp !== exp_q[0].err) resp_bad = 1'b1;
                        if (!m_ready) begin
                            waits++;
                        end else begin
                            e = exp_q.pop_front();
                            check("wait_cycles", 32'(waits), 32'(e.nwait));
                            check("hresp", 32'(resp_bad), 32'd0);
                            check("hrdata", m_rdata, e.rdata);
                            waits    = 0;
                            resp_bad = 1'b0;
                            in_data  = 1'b0;
                        end
                    end
                end else begin
                    check("idle_ready_resp", {30'd0, m_ready, m_resp}, 32'd2);
                end
                if (tb_hsel && tb_htrans[1] && m_ready) in_data = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        tb_hsel   = 1'b0;
        tb_htrans = TrIdle;
        tb_hwrite = 1'b0;
        tb_haddr  = '0;
        tb_hsize  = SzWord;
        tb_hwdata = '0;
        dsel      = 2'd0;
        clear_model();
        repeat (2) @(negedge hclk);
        for (int d = 0; d < 3; d++) begin
            dsel = 2'(d);
            #1;
            check("rst_hreadyout", 32'(m_ready), 32'd1);
            check("rst_hresp", 32'(m_resp), 32'd0);
            check("rst_hrdata", m_rdata, 32'd0);
        end
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // One wait state: write then read back.
        dsel = 2'd1;
        issue(1'b1, TrNonseq, 1'b1, 32'h4, SzWord, 32'h0000_0001);
        issue(1'b1, TrNonseq, 1'b0, 32'h4, SzWord, 32'h0);
        finish_seq();

        // Zero wait states: write then immediate read of the same word (forwarding).
        dsel = 2'd0;
        issue(1'b1, TrNonseq, 1'b1, 32'h8, SzWord, 32'hDEAD_BEEF);
        issue(1'b1, TrNonseq, 0, 32'h8, SzWord, 32'h0);
        issue(1'b1, TrNonseq, 1'b1, 32'h3C, SzWord, 32'h0BAD_F00D);
        issue(1'b1, TrNonseq, 1'b0, 32'h3C, SzWord, 32'h0);
        finish_seq();

        // Error responses: out of range, half-word, misaligned read, misaligned write.
        dsel = 2'd1;
        issue(1'b1, TrNonseq, 1'b0, 32'h40, SzWord, 32'h0);
        issue(1'b1, TrNonseq, 1'b0, 32'h0, 3'b001, 32'h0);
        issue(1'b1, TrNonseq, 1'b0, 32'h6, SzWord, 32'h0);
        issue(1'b1, TrNonseq, 1'b1, 32'h2, SzWord, 32'hFFFF_FFFF);
        issue(1'b1, TrNonseq, 1'b0, 32'h0, SzWord, 32'h0);
        finish_seq();

        // BUSY and unselected writes must not reach memory.
        issue(1'b1, TrBusy, 1'b1, 32'h0, SzWord, 32'h1234_5678);
        issue(1'b0, TrNonseq, 1'b1, 32'h0, SzWord, 32'h1234_5678);
        issue(1'b1, TrNonseq, 1'b0, 32'h0, SzWord, 32'h0);
        finish_seq();

        // Three wait states: only hwdata present in LAST is stored.
        dsel = 2'd2;
        issue(1'b1, TrNonseq, 1'b1, 32'hC, SzWord, 32'hA5A5_A5A5);
        tb_hsel   = 1'b0;
        tb_htrans = TrIdle;
        tb_hwdata = 32'h1111_1111;
        @(posedge hclk);
        #1;
        tb_hwdata = 32'h2222_2222;
        @(posedge hclk);
        #1;
        tb_hwdata = 32'h3333_3333;
        @(posedge hclk);
        #1;
        tb_hwdata = 32'hA5A5_A5A5;
        issue(1'b1, TrNonseq, 1'b0, 32'hC, SzWord, 32'h0);
        finish_seq();

        // Reset in the middle of a write's wait state drops the write.
        dsel = 2'd1;
        issue(1'b1, TrNonseq, 1'b0, 32'h4, SzWord, 32'h0);
        issue(1'b1, TrNonseq, 1'b1, 32'h4, SzWord, 32'hCAFE_F00D);
        tb_hsel   = 1'b0;
        tb_htrans = TrIdle;
        #1;
        check("wait_before_reset", 32'(m_ready), 32'd0);
        hresetn = 1'b0;
        #1;
        check("async_rst_hreadyout", 32'(m_ready), 32'd1);
        check("async_rst_hresp", 32'(m_resp), 32'd0);
        check("async_rst_hrdata", m_rdata, 32'd0);
        clear_model();
        @(negedge hclk);
        exp_q.delete();
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        issue(1'b1, TrNonseq, 1'b0, 32'h4, SzWord, 32'h0);
        finish_seq();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
